// File: rtl/pio_out_pkg.sv
// Shared register offsets and byte-lane helper for the multi-channel output PIO.
package pio_out_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_BLINK = 2'd1;
  localparam logic [1:0] REG_SET   = 2'd2;
  localparam logic [1:0] REG_CLR   = 2'd3;

  // Expands the 4-bit byteenable into a 32-bit bit mask, one byte per lane
  function automatic logic [31:0] laneMask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/pio_blink_prescaler.sv
// Free-running blink prescaler: phase flips every DIV clock cycles.
module pio_blink_prescaler #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic reset,
  output logic phase
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  // Counter wraps at DIV-1 and the wrap is what toggles the phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/avalon_pio_out_multi.sv
// Avalon-MM output PIO with NUM_CH channels, atomic set/clear, byte lanes and blink masks.
module avalon_pio_out_multi
  import pio_out_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_CH    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               BLINK_DIV = 25000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write_n,
  input  logic [3:0]                byteenable,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH*WIDTH-1:0]   out_port
);

  logic                    w_wr;
  logic                    w_rd;
  logic [1:0]              w_off;
  logic [31:0]             w_chan;
  logic [31:0]             w_laneMask;
  logic [WIDTH-1:0]        w_wmask;
  logic [WIDTH-1:0]        w_wdata;
  logic                    w_phase;
  logic [NUM_CH*WIDTH-1:0] w_dataFlat;
  logic [NUM_CH*WIDTH-1:0] w_blinkFlat;
  logic [31:0]             w_rdVal;
  logic [31:0]             r_readdata;

  assign w_wr       = chipselect & ~write_n;
  assign w_rd       = chipselect & read;
  assign w_off      = address[1:0];
  assign w_chan     = 32'(address >> 2);
  assign w_laneMask = laneMask(byteenable);
  assign w_wmask    = w_laneMask[WIDTH-1:0];
  // Disabled lanes and bits above WIDTH contribute nothing to any write
  assign w_wdata    = writedata[WIDTH-1:0] & w_wmask;

  pio_blink_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .phase (w_phase)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink;
    logic             w_sel;

    assign w_sel = w_wr && (w_chan == 32'(c));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_data  <= RESET_VAL;
        r_blink <= '0;
      end else if (w_sel) begin
        case (w_off)
          REG_DATA:  r_data  <= (r_data & ~w_wmask) | w_wdata;
          REG_BLINK: r_blink <= (r_blink & ~w_wmask) | w_wdata;
          REG_SET:   r_data  <= r_data | w_wdata;
          REG_CLR:   r_data  <= r_data & ~w_wdata;
          default:   ;
        endcase
      end
    end

    assign w_dataFlat[c*WIDTH +: WIDTH]  = r_data;
    assign w_blinkFlat[c*WIDTH +: WIDTH] = r_blink;
    assign out_port[c*WIDTH +: WIDTH]    = r_data & ~(r_blink & {WIDTH{w_phase}});
  end

  // Out-of-range channels and the write-only offsets fall through to zero
  always_comb begin
    w_rdVal = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_chan == 32'(c)) begin
        case (w_off)
          REG_DATA:  w_rdVal[WIDTH-1:0] = w_dataFlat[c*WIDTH +: WIDTH];
          REG_BLINK: w_rdVal[WIDTH-1:0] = w_blinkFlat[c*WIDTH +: WIDTH];
          default:   w_rdVal = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd && !w_wr) begin
      r_readdata <= w_rdVal;
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_avalon_pio_out_multi.sv
// Directed and randomized checks of avalon_pio_out_multi against a bit-level reference model.
module tb_avalon_pio_out_multi;

  localparam logic [15:0] RV = 16'h00FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs0 = 1'b0;
  logic        cs1 = 1'b0;
  logic        rd = 1'b0;
  logic        wrN = 1'b1;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [4:0]  addr5 = '0;
  logic [31:0] readdata0;
  logic [31:0] readdata1;
  logic [63:0] outPort0;
  logic [79:0] outPort1;

  int checks = 0;
  int fails = 0;
  int n = 0;

  logic [15:0] modelData [4];
  logic [15:0] modelBlink [4];

  always #5 clk = ~clk;

  // Clock edges elapsed since the last reset edge; the blink phase is derived from it
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  avalon_pio_out_multi #(.WIDTH(16), .NUM_CH(4), .RESET_VAL(RV), .BLINK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .address(addr5[3:0]), .chipselect(cs0), .read(rd),
    .write_n(wrN), .byteenable(be), .writedata(wd), .readdata(readdata0), .out_port(outPort0)
  );

  avalon_pio_out_multi #(.WIDTH(16), .NUM_CH(5), .RESET_VAL(RV), .BLINK_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .address(addr5), .chipselect(cs1), .read(rd),
    .write_n(wrN), .byteenable(be), .writedata(wd), .readdata(readdata1), .out_port(outPort1)
  );

  function automatic logic curPhase();
    return ((n / 4) % 2) == 1;
  endfunction

  function automatic logic [63:0] expOut0();
    logic [63:0] v;
    for (int c = 0; c < 4; c++) begin
      v[c*16 +: 16] = modelData[c] & ~(modelBlink[c] & {16{curPhase()}});
    end
    return v;
  endfunction

  function automatic logic [31:0] expRead0(input int ch, input int off);
    if (off == 0) return {16'h0, modelData[ch]};
    if (off == 1) return {16'h0, modelBlink[ch]};
    return 32'h0;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 4; c++) begin
      modelData[c]  = RV;
      modelBlink[c] = 16'h0;
    end
  endtask

  // Bit-by-bit register rules: lane-gated copy, set-if-one, clear-if-one
  task automatic modelWrite(input int ch, input int off, input logic [3:0] bev, input logic [31:0] wdv);
    for (int i = 0; i < 16; i++) begin
      if (bev[i/8]) begin
        case (off)
          0: modelData[ch][i]  = wdv[i];
          1: modelBlink[ch][i] = wdv[i];
          2: if (wdv[i]) modelData[ch][i] = 1'b1;
          3: if (wdv[i]) modelData[ch][i] = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int dut, input int ch, input int off,
                               input logic [3:0] bev, input logic [31:0] wdv, input logic isRead);
    @(negedge clk);
    cs0   = (dut == 0);
    cs1   = (dut == 1);
    addr5 = 5'((ch << 2) | off);
    be    = bev;
    wd    = wdv;
    rd    = isRead;
    wrN   = isRead;
    @(negedge clk);
    cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0; wrN = 1'b1;
    if (dut == 0 && !isRead && ch < 4) modelWrite(ch, off, bev, wdv);
  endtask

  task automatic busWrite(input int dut, input int ch, input int off, input logic [3:0] bev, input logic [31:0] wdv);
    applyStimulus(dut, ch, off, bev, wdv, 1'b0);
  endtask

  task automatic busRead(input int dut, input int ch, input int off);
    applyStimulus(dut, ch, off, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    check(tag, {16'h0, outPort0}, {16'h0, expOut0()});
  endtask

  // Align so the next write edge falls inside a phase=1 half-period (early in it)
  task automatic waitPhaseStart();
    for (int k = 0; k < 20 && (n % 8) != 4; k++) @(negedge clk);
  endtask

  initial begin
    int ch, off;
    logic [3:0]  rbe;
    logic [31:0] rwd;

    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state on both instances
    check("reset_out0", {16'h0, outPort0}, {16'h0, 64'h00FF_00FF_00FF_00FF});
    check("reset_out1", outPort1, {5{RV}});
    check("reset_readdata", {48'h0, readdata0}, 80'h0);
    busRead(0, 2, 0);
    check("reset_read_ch2", {48'h0, readdata0}, {48'h0, 32'h0000_00FF});

    // Byte-lane write to DATA ch1
    busWrite(0, 1, 0, 4'b0001, 32'h1234_ABCD);
    check("be_write_slice", {64'h0, outPort0[31:16]}, {64'h0, 16'h00CD});
    checkOutput("be_write_out");

    // Atomic set / clear and write-only reads
    busWrite(0, 0, 0, 4'hF, 32'h0000_00F0);
    busWrite(0, 0, 2, 4'hF, 32'h0000_000F);
    busRead(0, 0, 0);
    check("outset_data", {48'h0, readdata0}, {48'h0, 32'h0000_00FF});
    busWrite(0, 0, 3, 4'hF, 32'h0000_0081);
    busRead(0, 0, 0);
    check("outclr_data", {48'h0, readdata0}, {48'h0, 32'h0000_007E});
    busRead(0, 0, 2);
    check("outset_reads0", {48'h0, readdata0}, 80'h0);
    busWrite(0, 0, 0, 4'hF, 32'hFFFF_FFFF);
    busRead(0, 0, 3);
    check("outclr_reads0", {48'h0, readdata0}, 80'h0);
    busWrite(0, 0, 0, 4'hF, 32'h0000_007E);
    busWrite(0, 0, 2, 4'hF, 32'h0);
    busWrite(0, 0, 3, 4'hF, 32'h0);
    check("setclr_zero_nochange", {64'h0, outPort0[15:0]}, {64'h0, 16'h007E});
    busWrite(0, 0, 2, 4'b0010, 32'h0000_00FF);
    check("set_disabled_lane", {64'h0, outPort0[15:0]}, {64'h0, 16'h007E});

    // Blink with a 4-cycle half period
    busWrite(0, 3, 0, 4'hF, 32'h0000_FFFF);
    busWrite(0, 3, 1, 4'hF, 32'h0000_0F0F);
    for (int k = 0; k < 16; k++) begin
      check("blink_ch3", {64'h0, outPort0[63:48]}, {64'h0, curPhase() ? 16'hF0F0 : 16'hFFFF});
      @(negedge clk);
    end
    waitPhaseStart();
    busWrite(0, 3, 0, 4'hF, 32'h0000_FFFF);
    busRead(0, 3, 1);
    check("data_keeps_blink", {48'h0, readdata0}, {48'h0, 32'h0000_0F0F});
    waitPhaseStart();
    busWrite(0, 3, 1, 4'hF, 32'h0);
    check("blink_clear_phase1", {64'h0, outPort0[63:48]}, {64'h0, 16'hFFFF});
    checkOutput("blink_clear_all");

    // Reset in the middle of a write while phase is 1
    busWrite(0, 0, 0, 4'hF, 32'h0000_1234);
    busWrite(0, 2, 1, 4'hF, 32'h0000_FFFF);
    busRead(0, 0, 0);
    waitPhaseStart();
    @(negedge clk);
    reset = 1'b1; cs0 = 1'b1; wrN = 1'b0; addr5 = 5'd0; be = 4'hF; wd = 32'h0000_FFFF;
    @(negedge clk);
    reset = 1'b0; cs0 = 1'b0; wrN = 1'b1;
    modelReset();
    check("midreset_out0", {16'h0, outPort0}, {16'h0, 64'h00FF_00FF_00FF_00FF});
    check("midreset_readdata", {48'h0, readdata0}, 80'h0);
    busWrite(0, 3, 1, 4'hF, 32'h0000_FFFF);
    for (int k = 0; k < 10; k++) begin
      checkOutput("post_reset_blink");
      @(negedge clk);
    end

    // Out-of-range channel on a 5-channel instance, and exact read latency
    busRead(1, 4, 0);
    check("dut1_ch4_read", {48'h0, readdata1}, {48'h0, 32'h0000_00FF});
    busWrite(1, 5, 0, 4'hF, 32'h0000_1111);
    busWrite(1, 6, 3, 4'hF, 32'h0000_FFFF);
    check("badch_nochange", outPort1, {5{RV}});
    @(negedge clk);
    cs1 = 1'b1; rd = 1'b1; addr5 = 5'((5 << 2) | 0);
    #1;
    check("latency_before_edge", {48'h0, readdata1}, {48'h0, 32'h0000_00FF});
    @(negedge clk);
    cs1 = 1'b0; rd = 1'b0;
    check("badch_read0", {48'h0, readdata1}, 80'h0);
    busRead(1, 4, 0);
    @(negedge clk);
    check("readdata_held", {48'h0, readdata1}, {48'h0, 32'h0000_00FF});

    // Randomized register traffic on the 4-channel instance
    for (int k = 0; k < 40; k++) begin
      ch  = $urandom_range(0, 3);
      off = $urandom_range(0, 3);
      rbe = 4'($urandom);
      rwd = $urandom;
      busWrite(0, ch, off, rbe, rwd);
      checkOutput("rand_out");
      ch  = $urandom_range(0, 3);
      off = $urandom_range(0, 3);
      busRead(0, ch, off);
      check("rand_read", {48'h0, readdata0}, {48'h0, expRead0(ch, off)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
